// File: rtl/result_collector_pkg.sv
// rtl/result_collector_pkg.sv - shared systolic-array constants, capture states and lane-width helper
package result_collector_pkg;

    localparam int SA_DATA_WIDTH = 16;
    localparam int SA_NUM_PE     = 8;
    // Cycles from launch to PE0's first valid result.
    localparam int PE_OFFSET     = 2;

    typedef enum logic {
        ST_IDLE,
        ST_CAPTURE
    } cap_state_e;

    function automatic int lane_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/result_collector_if.sv
// rtl/result_collector_if.sv - launch, PE result and serial output signals of the result collector
interface result_collector_if #(
    parameter int DATA_WIDTH = result_collector_pkg::SA_DATA_WIDTH,
    parameter int NUM_PE     = result_collector_pkg::SA_NUM_PE
) ();
    localparam int LANE_W = result_collector_pkg::lane_width(NUM_PE);

    logic                         launch_i;
    logic                         launch_ready_o;
    logic [NUM_PE*DATA_WIDTH-1:0] pe_out_i;
    logic                         out_valid_o;
    logic                         out_ready_i;
    logic [DATA_WIDTH-1:0]        out_data_o;
    logic [LANE_W-1:0]            out_lane_o;
    logic                         out_last_o;
    logic                         busy_o;

    modport master (
        output launch_i, pe_out_i, out_ready_i,
        input  launch_ready_o, out_valid_o, out_data_o, out_lane_o, out_last_o, busy_o
    );

    modport slave (
        input  launch_i, pe_out_i, out_ready_i,
        output launch_ready_o, out_valid_o, out_data_o, out_lane_o, out_last_o, busy_o
    );

endinterface

// File: rtl/result_collector_row_fifo.sv
// rtl/result_collector_row_fifo.sv - row_fifo: circular buffer of complete result rows
module row_fifo #(
    parameter int ROW_WIDTH = 128,
    parameter int ROW_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [ROW_WIDTH-1:0]           push_row,
    input  logic                           pop,
    output logic [ROW_WIDTH-1:0]           head_row,
    output logic [$clog2(ROW_DEPTH+1)-1:0] count
);
    localparam int PTR_W = (ROW_DEPTH > 1) ? $clog2(ROW_DEPTH) : 1;
    localparam int CNT_W = $clog2(ROW_DEPTH+1);

    logic [ROW_WIDTH-1:0] mem [ROW_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ROW_DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < CNT_W'(ROW_DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < ROW_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_row;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_row = mem[rd_ptr];

endmodule

// File: rtl/result_collector.sv
// rtl/result_collector.sv - captures skewed PE outputs into rows and serializes them lane by lane
module result_collector
    import result_collector_pkg::*;
#(
    parameter int DATA_WIDTH = SA_DATA_WIDTH,
    parameter int NUM_PE     = SA_NUM_PE,
    parameter int ROW_DEPTH  = 2
) (
    input  logic               clk,
    input  logic               reset,
    result_collector_if.slave  bus
);
    localparam int ROW_W      = NUM_PE * DATA_WIDTH;
    localparam int LANE_W     = lane_width(NUM_PE);
    localparam int CNT_W      = $clog2(NUM_PE + PE_OFFSET + 1);
    localparam int FIFO_CNT_W = $clog2(ROW_DEPTH + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NUM_PE + PE_OFFSET - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_PE - 1);

    cap_state_e            state;
    logic [CNT_W-1:0]      cnt;
    logic [ROW_W-1:0]      staging;
    logic [ROW_W-1:0]      push_row;
    logic [ROW_W-1:0]      head_row;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [LANE_W-1:0]     lane_idx;
    logic                  launch_ready;
    logic                  push;
    logic                  pop;
    logic                  out_valid;
    logic                  at_last_lane;
    logic                  handshake;

    assign launch_ready = (state == ST_IDLE) && (fifo_count < FIFO_CNT_W'(ROW_DEPTH));
    assign push         = (state == ST_CAPTURE) && (cnt == LAST_CNT);

    // The last lane arrives in the push cycle, so it bypasses the staging row.
    always_comb begin
        push_row = staging;
        push_row[(NUM_PE-1)*DATA_WIDTH +: DATA_WIDTH] = bus.pe_out_i[(NUM_PE-1)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            staging <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.launch_i && launch_ready) begin
                        state <= ST_CAPTURE;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    for (int k = 0; k < NUM_PE - 1; k++) begin
                        if (cnt == CNT_W'(k + PE_OFFSET)) begin
                            staging[k*DATA_WIDTH +: DATA_WIDTH] <= bus.pe_out_i[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    if (cnt == LAST_CNT) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    row_fifo #(
        .ROW_WIDTH (ROW_W),
        .ROW_DEPTH (ROW_DEPTH)
    ) u_row_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_row (push_row),
        .pop      (pop),
        .head_row (head_row),
        .count    (fifo_count)
    );

    assign out_valid    = (fifo_count != '0);
    assign at_last_lane = (lane_idx == LAST_LANE);
    assign handshake    = out_valid && bus.out_ready_i;
    assign pop          = handshake && at_last_lane;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_idx <= '0;
        end else if (handshake) begin
            lane_idx <= at_last_lane ? '0 : lane_idx + LANE_W'(1);
        end
    end

    assign bus.launch_ready_o = launch_ready;
    assign bus.out_valid_o    = out_valid;
    assign bus.out_data_o     = head_row[lane_idx*DATA_WIDTH +: DATA_WIDTH];
    assign bus.out_lane_o     = lane_idx;
    assign bus.out_last_o     = out_valid && at_last_lane;
    assign bus.busy_o         = (state == ST_CAPTURE) || out_valid;

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - randomized scoreboard bench for result_collector
module tb_result_collector;

    localparam int DW    = 16;
    localparam int NP    = 8;
    localparam int DEPTH = 2;
    localparam int RW    = DW * NP;
    localparam int LAT   = NP + 2;

    logic clk = 1'b0;
    logic reset;

    result_collector_if #(.DATA_WIDTH(DW), .NUM_PE(NP)) bus ();

    result_collector #(
        .DATA_WIDTH (DW),
        .NUM_PE     (NP),
        .ROW_DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    // Reference model: rows accepted in launch order, each visible LAT cycles after its launch.
    logic [RW-1:0] sb_row[$];
    int            sb_ready[$];
    int            head_lane  = 0;
    bit            cap_active = 1'b0;
    int            cap_l      = 0;
    logic [RW-1:0] cap_row;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic int buffered(input int n);
        int b = 0;
        foreach (sb_ready[i]) if (sb_ready[i] <= n) b++;
        return b;
    endfunction

    function automatic bit in_cap(input int n);
        return cap_active && (n >= cap_l + 1) && (n <= cap_l + LAT - 1);
    endfunction

    function automatic logic [DW-1:0] lane_of(input logic [RW-1:0] r, input int k);
        return r[k*DW +: DW];
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int k = 0; k < NP; k++) r[k*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    function automatic logic [RW-1:0] seq_row(input logic [DW-1:0] base);
        logic [RW-1:0] r;
        for (int k = 0; k < NP; k++) r[k*DW +: DW] = base + DW'(k);
        return r;
    endfunction

    task automatic model_clear();
        sb_row.delete();
        sb_ready.delete();
        head_lane  = 0;
        cap_active = 1'b0;
    endtask

    // Drives one cycle of inputs; called at posedge+1, returns at the next posedge+1.
    task automatic tick(input bit launch, input bit ready, input logic [RW-1:0] row);
        logic [RW-1:0] pe;
        int            k;
        if (launch && reset && !in_cap(cyc) && buffered(cyc) < DEPTH) begin
            cap_active = 1'b1;
            cap_l      = cyc;
            cap_row    = row;
            sb_row.push_back(row);
            sb_ready.push_back(cyc + LAT);
        end
        pe = rand_row();
        k  = cyc - cap_l - 2;
        if (cap_active && k >= 0 && k < NP) pe[k*DW +: DW] = lane_of(cap_row, k);
        bus.launch_i    = launch;
        bus.out_ready_i = ready;
        bus.pe_out_i    = pe;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input bit ready);
        for (int i = 0; i < n; i++) tick(1'b0, ready, rand_row());
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid_o), 32'd0);
        chk({tag, "_data"},  32'(bus.out_data_o),  32'd0);
        chk({tag, "_lane"},  32'(bus.out_lane_o),  32'd0);
        chk({tag, "_last"},  32'(bus.out_last_o),  32'd0);
        chk({tag, "_busy"},  32'(bus.busy_o),      32'd0);
    endtask

    always @(negedge clk) begin : monitor
        int nb;
        bit ev;
        nb = buffered(cyc);
        ev = (nb > 0);
        chk("launch_ready", 32'(bus.launch_ready_o), 32'(!in_cap(cyc) && nb < DEPTH));
        chk("busy",         32'(bus.busy_o),         32'(in_cap(cyc) || nb > 0));
        chk("out_valid",    32'(bus.out_valid_o),    32'(ev));
        if (ev) begin
            chk("out_data", 32'(bus.out_data_o), 32'(lane_of(sb_row[0], head_lane)));
            chk("out_lane", 32'(bus.out_lane_o), 32'(head_lane));
            chk("out_last", 32'(bus.out_last_o), 32'(head_lane == NP - 1));
            if (bus.out_ready_i) begin
                head_lane++;
                if (head_lane == NP) begin
                    head_lane = 0;
                    void'(sb_row.pop_front());
                    void'(sb_ready.pop_front());
                end
            end
        end
    end

    initial begin
        reset           = 1'b0;
        bus.launch_i    = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.pe_out_i    = '0;
        @(posedge clk);
        #1;
        check_reset_outputs("por");
        idle(2, 1'b0);
        reset = 1'b1;
        idle(3, 1'b1);

        // Single row, no backpressure.
        tick(1'b1, 1'b1, seq_row(16'h3C00));
        idle(20, 1'b1);

        // Backpressure in the first three output cycles.
        tick(1'b1, 1'b1, seq_row(16'h3C00));
        for (int i = 1; i < 25; i++) tick(1'b0, !(i >= 10 && i <= 12), rand_row());

        // Fill both rows with the output stalled; further launches must be refused.
        tick(1'b1, 1'b0, rand_row());
        idle(9, 1'b0);
        tick(1'b1, 1'b0, rand_row());
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, rand_row());
        idle(25, 1'b1);

        // Row B completes in the cycle row A hands off its last lane.
        tick(1'b1, 1'b0, rand_row());
        for (int i = 1; i < 32; i++) tick(i == 10, i >= 12, rand_row());
        idle(5, 1'b1);

        // Launch during capture is ignored.
        tick(1'b1, 1'b1, seq_row(16'h4000));
        idle(3, 1'b1);
        tick(1'b1, 1'b1, seq_row(16'h5000));
        idle(20, 1'b1);

        // Reset in cycle 5 of a capture, with an older row still buffered.
        tick(1'b1, 1'b0, rand_row());
        idle(10, 1'b0);
        tick(1'b1, 1'b0, rand_row());
        idle(4, 1'b0);
        bus.launch_i = 1'b0;
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        cyc++;
        idle(2, 1'b1);
        reset = 1'b1;
        idle(20, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, rand_row());
        end
        idle(40, 1'b1);
        chk("drained", 32'(sb_row.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 16, FP16 word width of each PE result.
REQ-002 Parameter NUM_PE, default 8, number of PE lanes in the 1-D array.
REQ-003 Parameter ROW_DEPTH, default 2, number of complete result rows buffered.
REQ-004 Port clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port launch_i  input  1  pulse in the cycle a row's first A/B operands are presented to PE0.
REQ-007 Port launch_ready_o  output  1  high when a launch is accepted this cycle.
REQ-008 Port pe_out_i  input  NUM_PE*DATA_WIDTH  concatenated PE_out buses, lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port out_valid_o  output  1  serial result word available.
REQ-010 Port out_ready_i  input  1  downstream accepts the word when high with out_valid_o.
REQ-011 Port out_data_o  output  DATA_WIDTH  result word.
REQ-012 Port out_lane_o  output  log2(NUM_PE)  lane index of out_data_o.
REQ-013 Port out_last_o  output  1  high with lane NUM_PE-1 of a row.
REQ-014 Port busy_o  output  1  high while a capture is in progress or any row is buffered.

Function
REQ-015 Capture FSM SHALL have states IDLE and CAPTURE, with a capture counter cnt of width to hold 0..NUM_PE+1.
REQ-016 launch_ready_o SHALL equal (state==IDLE) AND (buffered rows < ROW_DEPTH); launch_i while launch_ready_o is low SHALL be ignored.
REQ-017 An accepted launch in cycle 0 SHALL move IDLE->CAPTURE with cnt=1 at the end of cycle 0.
REQ-018 In cycle c (cnt=c), for c in 2..NUM_PE+1, lane k=c-2 of pe_out_i SHALL be sampled into the staging row at the end of cycle c.
REQ-019 At the end of cycle NUM_PE+1 (cycle 9 for NUM_PE=8), the staging row plus lane NUM_PE-1 SHALL be pushed as one row into the row FIFO, and the FSM SHALL return to IDLE.
REQ-020 launch_ready_o SHALL be high again in cycle NUM_PE+2 if FIFO space remains; back-to-back rows therefore launch every NUM_PE+2 cycles.
REQ-021 Serializer SHALL present the head row lanes 0..NUM_PE-1 in order, advancing one lane per cycle when out_valid_o and out_ready_i are both high.
REQ-022 out_data_o, out_lane_o and out_last_o SHALL hold stable while out_valid_o is high and out_ready_i is low.
REQ-023 The head row SHALL be popped on the handshake with out_last_o high; the lane index then wraps to 0.
REQ-024 First out_valid_o after a push into an empty FIFO SHALL be in cycle NUM_PE+2 (cycle 10).
REQ-025 Simultaneous push and pop in the same cycle SHALL leave the row count unchanged and both rows intact.
REQ-026 out_data_o SHALL be passed bit-exact; no FP16 arithmetic or rounding in this block.
REQ-027 FIFO full: no push can occur because launch is refused; FIFO empty: out_valid_o low, out_data_o value don't-care.

Reset
REQ-028 On reset low, state=IDLE, cnt=0, row count=0, lane index=0, staging row and FIFO cleared to 0, immediately and independent of clk.
REQ-029 Reset values: launch_ready_o=1 (after release), out_valid_o=0, out_data_o=0, out_lane_o=0, out_last_o=0, busy_o=0.
REQ-030 Reset mid-capture or mid-drain SHALL discard all partial and buffered rows; no stale word appears after release.

Structure
REQ-031 DATA_WIDTH, NUM_PE, the PE pipeline offset 2 and the lane-index width function SHALL live in the shared systolic-array package used by the PE and array top.
REQ-032 The row FIFO SHALL be one sub-module, row_fifo, parameterised by row width and ROW_DEPTH; capture FSM and serializer stay in result_collector.

Verification
REQ-033 Single row: launch cycle 0, lane k = 16'h3C00+k valid in cycle k+2, out_ready_i=1 -> words 3C00..3C07 in cycles 10..17, out_last_o in cycle 17.
REQ-034 Backpressure: same row, out_ready_i low cycles 10..12 -> lane 0 held stable cycles 10..13, lanes then consecutive, no loss or duplication.
REQ-035 Full buffer: out_ready_i=0, two rows launched at cycles 0 and 10 -> launch_ready_o low from cycle 11 onward, third launch ignored, two rows emitted intact once out_ready_i=1.
REQ-036 Concurrent push/pop: row B capture completes in the cycle row A pops last lane -> row count stays 1, row B emitted next unchanged.
REQ-037 Reset at cycle 5 of a capture -> all outputs at reset values asynchronously, no word emitted after release until a new launch.
REQ-038 launch_i asserted during CAPTURE -> ignored, captured row matches only the first launch.
